// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg
// Shared definitions for the MEM->WB pipeline register.
//   - default data/register-index widths and the maximum stage depth
//   - the stage-entry control layout (valid, reg_write, mem_to_reg)
//   - the bubble constant used for flushed or empty entries
//   - a helper that turns raw MEM-stage control into the stored form
package mem_wb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;
    localparam int DEPTH_MAX  = 4;

    // Control portion of one stage entry. Data fields (mem_data, alu,
    // dest) are carried beside it because their widths are parameters.
    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    localparam wb_ctrl_t CTRL_BUBBLE = '{valid: 1'b0, reg_write: 1'b0, mem_to_reg: 1'b0};

    // A non-valid MEM entry is stored with all control bits cleared so it
    // can never write the register file or be matched by forwarding.
    function automatic wb_ctrl_t ctrl_from_mem(input logic valid,
                                               input logic reg_write,
                                               input logic mem_to_reg);
        wb_ctrl_t c;
        c = CTRL_BUBBLE;
        if (valid) begin
            c.valid      = 1'b1;
            c.reg_write  = reg_write;
            c.mem_to_reg = mem_to_reg;
        end
        return c;
    endfunction

endpackage

// File: rtl/wb_stage_reg.sv
// wb_stage_reg
// One MEM->WB pipeline stage: asynchronous active-high reset, hold, and
// bubble load. Bubble has priority over hold so a flush lands even while
// the pipe is stalled.
// Ports:
//   clk, rst            clock / async active-high reset
//   i_hold              keep current contents
//   i_bubble            load an all-zero entry
//   i_ctrl, i_mem_data, i_alu, i_dest   entry to capture
//   o_ctrl, o_mem_data, o_alu, o_dest   stored entry
module wb_stage_reg
    import mem_wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_hold,
    input  logic              i_bubble,
    input  wb_ctrl_t          i_ctrl,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic [DATA_W-1:0] i_alu,
    input  logic [REG_W-1:0]  i_dest,
    output wb_ctrl_t          o_ctrl,
    output logic [DATA_W-1:0] o_mem_data,
    output logic [DATA_W-1:0] o_alu,
    output logic [REG_W-1:0]  o_dest
);

    wb_ctrl_t          r_ctrl;
    logic [DATA_W-1:0] r_mem_data;
    logic [DATA_W-1:0] r_alu;
    logic [REG_W-1:0]  r_dest;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl     <= CTRL_BUBBLE;
            r_mem_data <= '0;
            r_alu      <= '0;
            r_dest     <= '0;
        end else if (i_bubble) begin
            r_ctrl     <= CTRL_BUBBLE;
            r_mem_data <= '0;
            r_alu      <= '0;
            r_dest     <= '0;
        end else if (!i_hold) begin
            r_ctrl     <= i_ctrl;
            r_mem_data <= i_mem_data;
            r_alu      <= i_alu;
            r_dest     <= i_dest;
        end
    end

    assign o_ctrl     = r_ctrl;
    assign o_mem_data = r_mem_data;
    assign o_alu      = r_alu;
    assign o_dest     = r_dest;

endmodule

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe
// Parametrised MEM->WB pipeline register (DEPTH stages, 1..DEPTH_MAX) with
// stall, flush, per-entry valid, write-back data mux and retired counter.
// Optional feature macro: WB_FWD_EN -- adds src_a/src_b inputs and the
// fwd_* outputs with a youngest-first forwarding search over all stages.
// Ports:
//   clk, rst                          clock / async active-high reset
//   stall, flush                      hold all stages / bubble into s0
//   valid_in, mem_to_reg_in, reg_write_in, mem_data_in, alu_in, dest_in
//                                     MEM-stage entry
//   valid_out, reg_write_out, mem_to_reg_out, mem_data_out, alu_out,
//   dest_out, wb_data_out             last-stage entry and muxed WB value
//   retire_count                      retired write-back entries (wraps)
//   src_a, src_b, fwd_a_hit, fwd_b_hit, fwd_a_data, fwd_b_data
//                                     forwarding (WB_FWD_EN only)
module mem_wb_pipe
    import mem_wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic              mem_to_reg_in,
    input  logic              reg_write_in,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [REG_W-1:0]  dest_in,
    output logic              valid_out,
    output logic              reg_write_out,
    output logic              mem_to_reg_out,
    output logic [DATA_W-1:0] mem_data_out,
    output logic [DATA_W-1:0] alu_out,
    output logic [REG_W-1:0]  dest_out,
    output logic [DATA_W-1:0] wb_data_out,
    output logic [31:0]       retire_count
`ifdef WB_FWD_EN
    ,
    input  logic [REG_W-1:0]  src_a,
    input  logic [REG_W-1:0]  src_b,
    output logic              fwd_a_hit,
    output logic              fwd_b_hit,
    output logic [DATA_W-1:0] fwd_a_data,
    output logic [DATA_W-1:0] fwd_b_data
`endif
);

    wb_ctrl_t          w_ctrl [DEPTH];
    logic [DATA_W-1:0] w_mem  [DEPTH];
    logic [DATA_W-1:0] w_alu  [DEPTH];
    logic [REG_W-1:0]  w_dest [DEPTH];

    wb_ctrl_t          w_ctrl_in;
    logic [31:0]       r_retire_count;

    assign w_ctrl_in = ctrl_from_mem(valid_in, reg_write_in, mem_to_reg_in);

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_first
            wb_stage_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) u_stage (
                .clk        (clk),
                .rst        (rst),
                .i_hold     (stall),
                .i_bubble   (flush),
                .i_ctrl     (w_ctrl_in),
                .i_mem_data (mem_data_in),
                .i_alu      (alu_in),
                .i_dest     (dest_in),
                .o_ctrl     (w_ctrl[k]),
                .o_mem_data (w_mem[k]),
                .o_alu      (w_alu[k]),
                .o_dest     (w_dest[k])
            );
        end else begin : g_next
            wb_stage_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) u_stage (
                .clk        (clk),
                .rst        (rst),
                .i_hold     (stall),
                .i_bubble   (1'b0),
                .i_ctrl     (w_ctrl[k-1]),
                .i_mem_data (w_mem[k-1]),
                .i_alu      (w_alu[k-1]),
                .i_dest     (w_dest[k-1]),
                .o_ctrl     (w_ctrl[k]),
                .o_mem_data (w_mem[k]),
                .o_alu      (w_alu[k]),
                .o_dest     (w_dest[k])
            );
        end
    end

    assign valid_out      = w_ctrl[DEPTH-1].valid;
    assign reg_write_out  = w_ctrl[DEPTH-1].valid & w_ctrl[DEPTH-1].reg_write;
    assign mem_to_reg_out = w_ctrl[DEPTH-1].mem_to_reg;
    assign mem_data_out   = w_mem[DEPTH-1];
    assign alu_out        = w_alu[DEPTH-1];
    assign dest_out       = w_dest[DEPTH-1];
    assign wb_data_out    = mem_to_reg_out ? mem_data_out : alu_out;

    // An entry retires on the edge that moves it out of the last stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retire_count <= '0;
        end else if (!stall && valid_out) begin
            r_retire_count <= r_retire_count + 32'd1;
        end
    end

    assign retire_count = r_retire_count;

`ifdef WB_FWD_EN
    // Youngest-first search: the first matching stage from s0 wins, so a
    // newer producer shadows an older one for the same register.
    always_comb begin
        fwd_a_hit  = 1'b0;
        fwd_a_data = '0;
        fwd_b_hit  = 1'b0;
        fwd_b_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!fwd_a_hit && (src_a != '0) && w_ctrl[k].valid &&
                w_ctrl[k].reg_write && (w_dest[k] == src_a)) begin
                fwd_a_hit  = 1'b1;
                fwd_a_data = w_ctrl[k].mem_to_reg ? w_mem[k] : w_alu[k];
            end
            if (!fwd_b_hit && (src_b != '0) && w_ctrl[k].valid &&
                w_ctrl[k].reg_write && (w_dest[k] == src_b)) begin
                fwd_b_hit  = 1'b1;
                fwd_b_data = w_ctrl[k].mem_to_reg ? w_mem[k] : w_alu[k];
            end
        end
    end
`endif

endmodule
